// File: rtl/pm_jtag_dr_bank.sv
// JTAG data-register bank: one shared capture/shift path serving an IDCODE, NUM_REGS-1
// status/control registers and a 1-bit bypass, with shift-length checking on update.
module pm_jtag_dr_bank #(
    parameter int unsigned          DR_WIDTH        = 32,
    parameter int unsigned          NUM_REGS        = 4,
    parameter int unsigned          SEL_WIDTH       = 2,
    parameter logic [DR_WIDTH-1:0]  IDCODE_VALUE    = 32'hBA20A005,
    parameter logic [DR_WIDTH-1:0]  UPD_RESET_VALUE = '0
) (
    input  logic                         reg_tck,
    input  logic                         reg_rst_n,
    input  logic                         reg_tdi,
    input  logic [SEL_WIDTH-1:0]         reg_sel,
    input  logic                         reg_capture_en,
    input  logic                         reg_shift_enable,
    input  logic                         reg_update_en,
    input  logic [NUM_REGS*DR_WIDTH-1:0] reg_cap_data,
    input  logic                         reg_len_err_clr,
    output logic                         reg_out,
    output logic [NUM_REGS*DR_WIDTH-1:0] reg_upd_data,
    output logic [NUM_REGS-1:0]          reg_upd_strobe,
    output logic                         reg_len_err
);

    localparam int unsigned CntW = $clog2(DR_WIDTH + 2);
    localparam logic [CntW-1:0] CntMax = CntW'(DR_WIDTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DR_WIDTH);

    logic [DR_WIDTH-1:0]  r_shift;
    logic                 r_bypass;
    logic [SEL_WIDTH-1:0] r_sel;
    logic [CntW-1:0]      r_cnt;
    logic [DR_WIDTH-1:0]  r_shadow [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]  r_strobe;
    logic                 r_err;

    logic                 w_cap_valid;
    logic                 w_sel_valid;
    logic                 w_upd_go;
    logic                 w_len_ok;
    logic [DR_WIDTH-1:0]  w_cap_slice;
    logic                 w_unused_cap0;

    // Slice 0 of the capture bus has no consumer; IDCODE is a constant.
    assign w_unused_cap0 = ^reg_cap_data[DR_WIDTH-1:0];

    assign w_cap_valid = 32'(reg_sel) < NUM_REGS;
    assign w_sel_valid = 32'(r_sel) < NUM_REGS;
    assign w_len_ok    = (r_cnt == CntFull);
    assign w_upd_go    = reg_update_en && !reg_capture_en && !reg_shift_enable &&
                         w_sel_valid && (r_sel != '0);

    always_comb begin
        w_cap_slice = '0;
        for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (reg_sel == SEL_WIDTH'(i)) begin
                w_cap_slice = reg_cap_data[i*DR_WIDTH +: DR_WIDTH];
            end
        end
    end

    // Shared capture/shift path; capture outranks shift.
    always_ff @(posedge reg_tck or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            r_shift  <= IDCODE_VALUE;
            r_bypass <= 1'b0;
            r_sel    <= '0;
            r_cnt    <= '0;
        end else if (reg_capture_en) begin
            r_sel <= reg_sel;
            r_cnt <= '0;
            if (reg_sel == '0) begin
                r_shift <= IDCODE_VALUE;
            end else if (w_cap_valid) begin
                r_shift <= w_cap_slice;
            end else begin
                r_bypass <= 1'b0;
            end
        end else if (reg_shift_enable) begin
            if (w_sel_valid) begin
                r_shift <= {reg_tdi, r_shift[DR_WIDTH-1:1]};
            end else begin
                r_bypass <= reg_tdi;
            end
            if (r_cnt != CntMax) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Update shadows, one-cycle strobes and the sticky length error.
    always_ff @(posedge reg_tck or negedge reg_rst_n) begin
        if (!reg_rst_n) begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                r_shadow[i] <= UPD_RESET_VALUE;
            end
            r_strobe <= '0;
            r_err    <= 1'b0;
        end else begin
            r_strobe <= '0;
            if (w_upd_go && w_len_ok) begin
                for (int i = 1; i < int'(NUM_REGS); i++) begin
                    if (r_sel == SEL_WIDTH'(i)) begin
                        r_shadow[i] <= r_shift;
                        r_strobe[i] <= 1'b1;
                    end
                end
            end
            if (w_upd_go && !w_len_ok) begin
                r_err <= 1'b1;
            end else if (reg_len_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign reg_out        = w_sel_valid ? r_shift[0] : r_bypass;
    assign reg_upd_strobe = {r_strobe, 1'b0};
    assign reg_len_err    = r_err;

    assign reg_upd_data[DR_WIDTH-1:0] = '0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_upd
        assign reg_upd_data[g*DR_WIDTH +: DR_WIDTH] = r_shadow[g];
    end

endmodule

// File: tb/tb_pm_jtag_dr_bank.sv
// Scoreboard bench for pm_jtag_dr_bank: a 4-register build plus a 3-register build for bypass.
module tb_pm_jtag_dr_bank;

    localparam int KOut  = 0;
    localparam int KStb  = 1;
    localparam int KUpd  = 2;
    localparam int KErr  = 3;
    localparam int KOut3 = 4;
    localparam int KStb3 = 5;
    localparam int KUpd3 = 6;
    localparam int KErr3 = 7;

    typedef struct {
        int           cyc;
        int           kind;
        logic [127:0] exp;
        string        name;
    } sb_item_t;

    logic         reg_tck = 1'b0;
    logic         reg_rst_n = 1'b0;
    logic         reg_tdi = 1'b0;
    logic [1:0]   reg_sel = '0;
    logic         reg_capture_en = 1'b0;
    logic         reg_shift_enable = 1'b0;
    logic         reg_update_en = 1'b0;
    logic [127:0] reg_cap_data = '0;
    logic         reg_len_err_clr = 1'b0;
    logic         reg_out;
    logic [127:0] reg_upd_data;
    logic [3:0]   reg_upd_strobe;
    logic         reg_len_err;
    logic         out3;
    logic [95:0]  upd3;
    logic [2:0]   stb3;
    logic         err3;

    sb_item_t sb[$];
    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;

    logic [31:0]  id_v   = 32'hBA20A005;
    logic [31:0]  cap2_v = 32'h12345678;
    logic [31:0]  din_v  = 32'hCAFEF00D;
    logic [127:0] upd_after = {32'h0, 32'hCAFEF00D, 64'h0};

    pm_jtag_dr_bank u_dut (
        .reg_tck          (reg_tck),
        .reg_rst_n        (reg_rst_n),
        .reg_tdi          (reg_tdi),
        .reg_sel          (reg_sel),
        .reg_capture_en   (reg_capture_en),
        .reg_shift_enable (reg_shift_enable),
        .reg_update_en    (reg_update_en),
        .reg_cap_data     (reg_cap_data),
        .reg_len_err_clr  (reg_len_err_clr),
        .reg_out          (reg_out),
        .reg_upd_data     (reg_upd_data),
        .reg_upd_strobe   (reg_upd_strobe),
        .reg_len_err      (reg_len_err)
    );

    pm_jtag_dr_bank #(.NUM_REGS(3)) u_dut3 (
        .reg_tck          (reg_tck),
        .reg_rst_n        (reg_rst_n),
        .reg_tdi          (reg_tdi),
        .reg_sel          (reg_sel),
        .reg_capture_en   (reg_capture_en),
        .reg_shift_enable (reg_shift_enable),
        .reg_update_en    (reg_update_en),
        .reg_cap_data     (reg_cap_data[95:0]),
        .reg_len_err_clr  (reg_len_err_clr),
        .reg_out          (out3),
        .reg_upd_data     (upd3),
        .reg_upd_strobe   (stb3),
        .reg_len_err      (err3)
    );

    always #5 reg_tck = ~reg_tck;

    always @(posedge reg_tck) cyc <= cyc + 1;

    // Monitor: pops every expectation due by this cycle, away from the active edge.
    always @(negedge reg_tck) begin
        sb_item_t     it;
        logic [127:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            case (it.kind)
                KOut:    act = 128'(reg_out);
                KStb:    act = 128'(reg_upd_strobe);
                KUpd:    act = reg_upd_data;
                KErr:    act = 128'(reg_len_err);
                KOut3:   act = 128'(out3);
                KStb3:   act = 128'(stb3);
                KUpd3:   act = 128'(upd3);
                default: act = 128'(err3);
            endcase
            checks = checks + 1;
            if (act !== it.exp) begin
                errors = errors + 1;
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", it.name, act, it.exp, cyc);
            end
        end
    end

    task automatic exp_next(input int kind, input string name, input logic [127:0] v);
        sb.push_back('{cyc + 1, kind, v, name});
    endtask

    task automatic exp_now(input int kind, input string name, input logic [127:0] v);
        sb.push_back('{cyc, kind, v, name});
    endtask

    task automatic step();
        @(posedge reg_tck);
        #1;
    endtask

    task automatic idle();
        reg_capture_en   = 1'b0;
        reg_shift_enable = 1'b0;
        reg_update_en    = 1'b0;
        reg_len_err_clr  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reg_cap_data = {32'h0BADF00D, 32'h12345678, 32'hA5A50002, 32'hFFFFFFFF};
        step();
        exp_now(KOut,  "rst_out",  1);
        exp_now(KStb,  "rst_stb",  0);
        exp_now(KErr,  "rst_err",  0);
        exp_now(KUpd,  "rst_upd",  0);
        exp_now(KOut3, "rst_out3", 1);
        reg_rst_n = 1'b1;

        // IDCODE capture and shift-out
        reg_sel = 2'd0;
        reg_capture_en = 1'b1;
        exp_next(KOut, "id_cap", 128'(id_v[0]));
        step();
        idle();
        for (int k = 1; k <= 32; k++) begin
            reg_shift_enable = 1'b1;
            reg_tdi = 1'b0;
            exp_next(KOut, $sformatf("id_shift%0d", k), (k < 32) ? 128'(id_v[k]) : 128'(0));
            step();
        end
        idle();
        reg_update_en = 1'b1;
        exp_next(KStb, "id_upd_stb", 0);
        exp_next(KErr, "id_upd_err", 0);
        step();
        idle();

        // Register 2: capture, shift, sel change mid-shift, update
        reg_sel = 2'd2;
        reg_capture_en = 1'b1;
        exp_next(KOut, "r2_cap", 128'(cap2_v[0]));
        step();
        idle();
        for (int k = 0; k < 32; k++) begin
            reg_shift_enable = 1'b1;
            reg_tdi = din_v[k];
            if (k == 16) reg_sel = 2'd1;
            exp_next(KOut, $sformatf("r2_shift%0d", k),
                     (k < 31) ? 128'(cap2_v[k+1]) : 128'(din_v[0]));
            step();
        end
        idle();
        reg_update_en = 1'b1;
        exp_next(KStb,  "r2_upd_stb",  4'b0100);
        exp_next(KUpd,  "r2_upd_data", upd_after);
        exp_next(KStb3, "r2_upd_stb3", 3'b100);
        exp_next(KUpd3, "r2_upd_data3", upd_after[95:0]);
        step();
        idle();
        exp_next(KStb, "r2_stb_drop", 0);
        exp_next(KUpd, "r2_upd_hold", upd_after);
        step();
        reg_update_en = 1'b1;
        exp_next(KStb, "r2_upd_repeat", 4'b0100);
        step();
        idle();
        exp_next(KStb, "r2_repeat_drop", 0);
        step();

        // Register 1: short and long shifts are rejected
        reg_sel = 2'd1;
        reg_capture_en = 1'b1;
        exp_next(KOut, "r1_cap", 0);
        step();
        idle();
        for (int k = 0; k < 31; k++) begin
            reg_shift_enable = 1'b1;
            reg_tdi = 1'b1;
            if (k == 0) exp_next(KOut, "r1_shift1", 1);
            step();
        end
        idle();
        reg_update_en = 1'b1;
        exp_next(KStb, "short_stb", 0);
        exp_next(KErr, "short_err", 1);
        exp_next(KUpd, "short_upd", upd_after);
        exp_next(KErr3, "short_err3", 1);
        step();
        idle();
        reg_len_err_clr = 1'b1;
        exp_next(KErr, "clr_err", 0);
        step();
        idle();
        reg_capture_en = 1'b1;
        step();
        idle();
        for (int k = 0; k < 33; k++) begin
            reg_shift_enable = 1'b1;
            step();
        end
        idle();
        reg_update_en = 1'b1;
        exp_next(KStb, "long_stb", 0);
        exp_next(KErr, "long_err", 1);
        exp_next(KUpd, "long_upd", upd_after);
        step();
        idle();
        reg_len_err_clr = 1'b1;
        exp_next(KErr, "clr_err2", 0);
        step();
        reg_update_en = 1'b1;
        exp_next(KErr, "set_beats_clr", 1);
        step();
        idle();
        reg_len_err_clr = 1'b1;
        exp_next(KErr, "clr_err3", 0);
        exp_next(KErr3, "clr_err3_b", 0);
        step();
        idle();

        // Bypass on the 3-register build
        reg_sel = 2'd3;
        reg_capture_en = 1'b1;
        exp_next(KOut3, "byp_cap", 0);
        step();
        idle();
        reg_shift_enable = 1'b1;
        reg_tdi = 1'b1;
        exp_next(KOut3, "byp_shift1", 1);
        step();
        reg_tdi = 1'b0;
        exp_next(KOut3, "byp_shift2", 0);
        step();
        reg_tdi = 1'b1;
        exp_next(KOut3, "byp_shift3", 1);
        step();
        idle();
        reg_update_en = 1'b1;
        exp_next(KStb3, "byp_upd_stb3", 0);
        exp_next(KErr3, "byp_upd_err3", 0);
        exp_next(KUpd3, "byp_upd_data3", upd_after[95:0]);
        step();
        idle();

        // Reset in the middle of a shift
        reg_sel = 2'd2;
        reg_capture_en = 1'b1;
        step();
        idle();
        reg_tdi = 1'b0;
        for (int k = 0; k < 5; k++) begin
            reg_shift_enable = 1'b1;
            step();
        end
        idle();
        @(negedge reg_tck);
        #1;
        reg_rst_n = 1'b0;
        exp_now(KOut,  "mid_rst_out",  1);
        exp_now(KUpd,  "mid_rst_upd",  0);
        exp_now(KErr,  "mid_rst_err",  0);
        exp_now(KStb,  "mid_rst_stb",  0);
        exp_now(KUpd3, "mid_rst_upd3", 0);
        step();
        reg_rst_n = 1'b1;
        step();
        reg_update_en = 1'b1;
        exp_next(KErr, "post_rst_upd_err", 0);
        exp_next(KStb, "post_rst_upd_stb", 0);
        step();
        idle();
        step();
        step();
        step();

        if (sb.size() != 0) begin
            errors = errors + sb.size();
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pm_jtag_dr_bank.md
# pm_jtag_dr_bank

Parametrised JTAG data-register bank for the power-management controller's JTAG interface, in the TCK domain beside the TAP controller. It provides one shared capture/shift path serving NUM_REGS selectable data registers. Register 0 is a read-only IDCODE; registers 1..NUM_REGS-1 capture parallel status and update parallel control shadows. Unselected codes fall back to a 1-bit bypass. The block adds shift-length checking that suppresses corrupted updates and raises a sticky error.

## Interface
- DR_WIDTH, 32: data-register length in bits, >= 2.
- NUM_REGS, 4: number of registers including IDCODE at index 0, >= 2.
- SEL_WIDTH, 2: select width; NUM_REGS <= 2**SEL_WIDTH.
- IDCODE_VALUE, 32'hBA20A005: DR_WIDTH-bit IDCODE constant; bit 0 = 1.
- UPD_RESET_VALUE, 0: DR_WIDTH-bit reset value of every update shadow.

Ports:
- reg_tck  in  1  JTAG TCK; all state on rising edge.
- reg_rst_n  in  1  reset, asynchronous, active-low.
- reg_tdi  in  1  serial data in.
- reg_sel  in  SEL_WIDTH  register select from instruction decode.
- reg_capture_en  in  1  Capture-DR qualifier.
- reg_shift_enable  in  1  Shift-DR qualifier.
- reg_update_en  in  1  Update-DR qualifier.
- reg_cap_data  in  NUM_REGS*DR_WIDTH  parallel capture values; slice i = bits [i*DR_WIDTH +: DR_WIDTH]; slice 0 unused.
- reg_len_err_clr  in  1  clears the sticky length error.
- reg_out  out  1  serial data out (TDO source).
- reg_upd_data  out  NUM_REGS*DR_WIDTH  update shadows; slice 0 is always 0.
- reg_upd_strobe  out  NUM_REGS  one-TCK pulse per register on a successful update; bit 0 is always 0.
- reg_len_err  out  1  sticky: an update was attempted with the wrong shift count.

## Operation
- State: shift_q[DR_WIDTH], bypass_q, sel_q[SEL_WIDTH], cnt_q (width clog2(DR_WIDTH+2), saturates at DR_WIDTH+1), shadow[1..NUM_REGS-1], strobe_q, err_q.
- Reset values: shift_q = IDCODE_VALUE, bypass_q = 0, sel_q = 0, cnt_q = 0, shadows = UPD_RESET_VALUE, strobe_q = 0, err_q = 0. Resulting outputs: reg_out = 1, reg_upd_strobe = 0, reg_len_err = 0.
- Priority per edge: capture > shift > update. At most one acts.
- Capture:
  - sel_q <= reg_sel; cnt_q <= 0.
  - reg_sel = 0: shift_q <= IDCODE_VALUE.
  - 1 <= reg_sel < NUM_REGS: shift_q <= slice reg_sel of reg_cap_data.
  - reg_sel >= NUM_REGS (bypass): bypass_q <= 0.
- Shift:
  - Valid sel_q: shift_q <= {reg_tdi, shift_q[DR_WIDTH-1:1]}.
  - Bypass: bypass_q <= reg_tdi.
  - cnt_q increments, saturating.
- Update, sel_q in 1..NUM_REGS-1:
  - cnt_q == DR_WIDTH: shadow[sel_q] <= shift_q and strobe_q[sel_q] <= 1.
  - Otherwise: shadow unchanged, no strobe, err_q <= 1.
- Update with sel_q = 0 or bypass: no effect, no error.
- strobe_q clears on every edge unless it is set on that edge.
- reg_len_err_clr clears err_q. A set on the same edge wins.
- reg_out = bypass_q when sel_q >= NUM_REGS; otherwise shift_q[0]. Pure combinational mux on registered state.
- reg_sel is sampled only at capture. Changes during shift or update are ignored.

## Timing
- Capture to first bit: bit 0 of the captured value is on reg_out immediately after the capture edge. Each shift edge presents the next bit.
- Update: reg_upd_data and reg_upd_strobe change on the update edge itself. The strobe is high for exactly one TCK cycle.
- Back-to-back updates with no intervening capture: cnt_q is unchanged, so the second update repeats the same write and strobe.
- Shifting more than DR_WIDTH bits: cnt_q saturates at DR_WIDTH+1. The subsequent update is rejected and sets the error.
- Reset mid-operation: every register returns to its reset value immediately. The next update without a capture sees cnt_q = 0 and sets the error for sel_q 1..NUM_REGS-1. Since sel_q resets to 0 (IDCODE), this happens only after a capture selecting such a register.

## Test plan
- Reset release, sel 0, capture, 32 shifts with tdi = 0 -> reg_out sequence 1,0,1,0,0,0,0,0,0,0,0,0,0,1,0,1,... = 0xBA20A005 LSB first; update gives no strobe, err stays 0.
- sel 2, cap_data slice 2 = 0x12345678, capture, shift in 0xCAFEF00D over 32 edges -> reg_out emits 0x12345678 LSB first; update -> reg_upd_data slice 2 = 0xCAFEF00D, reg_upd_strobe = 4'b0100 for one cycle.
- sel 1, capture, 31 shifts, update -> slice 1 keeps 0, no strobe, reg_len_err = 1. Repeat with 33 shifts -> same. reg_len_err_clr -> 0.
- sel 3 (NUM_REGS = 3 build), capture, shift 1,0,1 -> reg_out 0,1,0,1 lagging by one bit; update has no effect.
- reg_sel changed from 2 to 1 mid-shift -> update still writes slice 2.
- reg_rst_n low mid-shift -> reg_out = 1, all shadows 0, err 0.
- Same edge clr and error -> err = 1.
